rs_station: RTL and testbench

- Reservation station for non-memory instructions; sits directly downstream of the dispatch stage and upstream of the ALU.
- Buffers dispatched ops with their operand tags and values.
- Snoops both CDB buses (ALU, load) to resolve pending operands.
- Issues at most one ready entry per cycle to the ALU through registered outputs.

---
 rtl/rs_station.sv | 210 +++++++++++++++++++++
 tb/tb_rs_station.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_station.sv
// Reservation station for non-memory ops: buffers dispatched ops, snoops the ALU/load CDBs
// to resolve operand tags, and issues the lowest-index ready entry to the ALU each cycle.
module rs_station #(
    parameter int unsigned RS_SIZE   = 16,
    parameter int unsigned ROB_IDX_W = 4,
    parameter int unsigned OPT_W     = 6,
    parameter int unsigned WORD_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rb,
    output logic                 rs_full,
    input  logic                 rs_ena,
    input  logic [OPT_W-1:0]     rs_opt,
    input  logic [ROB_IDX_W-1:0] rs_src1,
    input  logic [ROB_IDX_W-1:0] rs_src2,
    input  logic [WORD_W-1:0]    rs_val1,
    input  logic [WORD_W-1:0]    rs_val2,
    input  logic [WORD_W-1:0]    rs_imm,
    input  logic [ROB_IDX_W-1:0] rs_rob_idx,
    input  logic                 cdb_alu_valid,
    input  logic [ROB_IDX_W-1:0] cdb_alu_src,
    input  logic [WORD_W-1:0]    cdb_alu_val,
    input  logic                 cdb_ld_valid,
    input  logic [ROB_IDX_W-1:0] cdb_ld_src,
    input  logic [WORD_W-1:0]    cdb_ld_val,
    output logic                 alu_ena,
    output logic [OPT_W-1:0]     alu_opt,
    output logic [WORD_W-1:0]    alu_val1,
    output logic [WORD_W-1:0]    alu_val2,
    output logic [WORD_W-1:0]    alu_imm,
    output logic [ROB_IDX_W-1:0] alu_rob_idx
);

    localparam int unsigned IDX_W = $clog2(RS_SIZE);
    localparam int unsigned CNT_W = $clog2(RS_SIZE + 1);

    typedef struct packed {
        logic [OPT_W-1:0]     opt;
        logic [ROB_IDX_W-1:0] src1;
        logic [ROB_IDX_W-1:0] src2;
        logic [WORD_W-1:0]    val1;
        logic [WORD_W-1:0]    val2;
        logic [WORD_W-1:0]    imm;
        logic [ROB_IDX_W-1:0] rob_idx;
    } entry_t;

    logic [RS_SIZE-1:0]   busy_q, busy_d;
    entry_t               ent_q [RS_SIZE];
    entry_t               ent_d [RS_SIZE];
    logic                 alu_ena_q, alu_ena_d;
    logic [OPT_W-1:0]     alu_opt_q, alu_opt_d;
    logic [WORD_W-1:0]    alu_val1_q, alu_val1_d;
    logic [WORD_W-1:0]    alu_val2_q, alu_val2_d;
    logic [WORD_W-1:0]    alu_imm_q, alu_imm_d;
    logic [ROB_IDX_W-1:0] alu_rob_idx_q, alu_rob_idx_d;
    logic                 rs_full_q, rs_full_d;

    logic                 issue_vld, free_vld;
    logic [IDX_W-1:0]     issue_idx, free_idx;
    logic [CNT_W-1:0]     free_cnt;
    entry_t               new_ent;

    function automatic logic cdb_hit(input logic                 vld,
                                     input logic [ROB_IDX_W-1:0] bus_tag,
                                     input logic [ROB_IDX_W-1:0] src);
        return vld && (src != '0) && (src == bus_tag);
    endfunction

    // Lowest-index ready and free slots, both judged on cycle-start state.
    always_comb begin
        issue_vld = 1'b0;
        issue_idx = '0;
        free_vld  = 1'b0;
        free_idx  = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (busy_q[i] && (ent_q[i].src1 == '0) && (ent_q[i].src2 == '0)) begin
                issue_vld = 1'b1;
                issue_idx = IDX_W'(i);
            end
            if (!busy_q[i]) begin
                free_vld = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    // Incoming op with same-cycle CDB forwarding; ALU bus wins over load bus.
    always_comb begin
        new_ent.opt     = rs_opt;
        new_ent.src1    = rs_src1;
        new_ent.src2    = rs_src2;
        new_ent.val1    = rs_val1;
        new_ent.val2    = rs_val2;
        new_ent.imm     = rs_imm;
        new_ent.rob_idx = rs_rob_idx;
        if (cdb_hit(cdb_alu_valid, cdb_alu_src, rs_src1)) begin
            new_ent.src1 = '0;
            new_ent.val1 = cdb_alu_val;
        end else if (cdb_hit(cdb_ld_valid, cdb_ld_src, rs_src1)) begin
            new_ent.src1 = '0;
            new_ent.val1 = cdb_ld_val;
        end
        if (cdb_hit(cdb_alu_valid, cdb_alu_src, rs_src2)) begin
            new_ent.src2 = '0;
            new_ent.val2 = cdb_alu_val;
        end else if (cdb_hit(cdb_ld_valid, cdb_ld_src, rs_src2)) begin
            new_ent.src2 = '0;
            new_ent.val2 = cdb_ld_val;
        end
    end

    always_comb begin
        busy_d        = busy_q;
        ent_d         = ent_q;
        alu_ena_d     = alu_ena_q;
        alu_opt_d     = alu_opt_q;
        alu_val1_d    = alu_val1_q;
        alu_val2_d    = alu_val2_q;
        alu_imm_d     = alu_imm_q;
        alu_rob_idx_d = alu_rob_idx_q;
        rs_full_d     = rs_full_q;
        free_cnt      = '0;

        if (rdy) begin
            alu_ena_d = 1'b0;
            if (rb) begin
                busy_d    = '0;
                rs_full_d = 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy_q[i]) begin
                        if (cdb_hit(cdb_alu_valid, cdb_alu_src, ent_q[i].src1)) begin
                            ent_d[i].src1 = '0;
                            ent_d[i].val1 = cdb_alu_val;
                        end else if (cdb_hit(cdb_ld_valid, cdb_ld_src, ent_q[i].src1)) begin
                            ent_d[i].src1 = '0;
                            ent_d[i].val1 = cdb_ld_val;
                        end
                        if (cdb_hit(cdb_alu_valid, cdb_alu_src, ent_q[i].src2)) begin
                            ent_d[i].src2 = '0;
                            ent_d[i].val2 = cdb_alu_val;
                        end else if (cdb_hit(cdb_ld_valid, cdb_ld_src, ent_q[i].src2)) begin
                            ent_d[i].src2 = '0;
                            ent_d[i].val2 = cdb_ld_val;
                        end
                    end
                end

                if (issue_vld) begin
                    alu_ena_d         = 1'b1;
                    alu_opt_d         = ent_q[issue_idx].opt;
                    alu_val1_d        = ent_q[issue_idx].val1;
                    alu_val2_d        = ent_q[issue_idx].val2;
                    alu_imm_d         = ent_q[issue_idx].imm;
                    alu_rob_idx_d     = ent_q[issue_idx].rob_idx;
                    busy_d[issue_idx] = 1'b0;
                end

                if (rs_ena && free_vld) begin
                    ent_d[free_idx]  = new_ent;
                    busy_d[free_idx] = 1'b1;
                end

                // Keep one slot spare for the op already sitting in the dispatch register.
                for (int i = 0; i < RS_SIZE; i++) begin
                    free_cnt = free_cnt + CNT_W'(!busy_d[i]);
                end
                rs_full_d = (free_cnt < CNT_W'(2));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q        <= '0;
            alu_ena_q     <= 1'b0;
            alu_opt_q     <= '0;
            alu_val1_q    <= '0;
            alu_val2_q    <= '0;
            alu_imm_q     <= '0;
            alu_rob_idx_q <= '0;
            rs_full_q     <= 1'b0;
        end else begin
            busy_q        <= busy_d;
            alu_ena_q     <= alu_ena_d;
            alu_opt_q     <= alu_opt_d;
            alu_val1_q    <= alu_val1_d;
            alu_val2_q    <= alu_val2_d;
            alu_imm_q     <= alu_imm_d;
            alu_rob_idx_q <= alu_rob_idx_d;
            rs_full_q     <= rs_full_d;
        end
    end

    // Payload needs no reset: it is only observed through busy entries.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    assign rs_full     = rs_full_q;
    assign alu_ena     = alu_ena_q;
    assign alu_opt     = alu_opt_q;
    assign alu_val1    = alu_val1_q;
    assign alu_val2    = alu_val2_q;
    assign alu_imm     = alu_imm_q;
    assign alu_rob_idx = alu_rob_idx_q;

endmodule

// File: tb/tb_rs_station.sv
// Bench for rs_station: directed scenarios plus random traffic, all checked against a
// slot-array reference model evaluated once per clock edge.
module tb_rs_station;

    localparam int RS = 16;

    logic        clk = 1'b0;
    logic        rst, rdy, rb;
    logic        rs_full, rs_ena;
    logic [5:0]  rs_opt;
    logic [3:0]  rs_src1, rs_src2, rs_rob_idx;
    logic [31:0] rs_val1, rs_val2, rs_imm;
    logic        cdb_alu_valid, cdb_ld_valid;
    logic [3:0]  cdb_alu_src, cdb_ld_src;
    logic [31:0] cdb_alu_val, cdb_ld_val;
    logic        alu_ena;
    logic [5:0]  alu_opt;
    logic [31:0] alu_val1, alu_val2, alu_imm;
    logic [3:0]  alu_rob_idx;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rs_station dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rb(rb), .rs_full(rs_full),
        .rs_ena(rs_ena), .rs_opt(rs_opt), .rs_src1(rs_src1), .rs_src2(rs_src2),
        .rs_val1(rs_val1), .rs_val2(rs_val2), .rs_imm(rs_imm), .rs_rob_idx(rs_rob_idx),
        .cdb_alu_valid(cdb_alu_valid), .cdb_alu_src(cdb_alu_src), .cdb_alu_val(cdb_alu_val),
        .cdb_ld_valid(cdb_ld_valid), .cdb_ld_src(cdb_ld_src), .cdb_ld_val(cdb_ld_val),
        .alu_ena(alu_ena), .alu_opt(alu_opt), .alu_val1(alu_val1), .alu_val2(alu_val2),
        .alu_imm(alu_imm), .alu_rob_idx(alu_rob_idx)
    );

    typedef struct {
        bit          busy;
        logic [5:0]  opt;
        logic [3:0]  s1, s2;
        logic [31:0] v1, v2, imm;
        logic [3:0]  rob;
    } slot_t;

    slot_t       m [RS];
    bit          m_ena, m_full;
    logic [5:0]  m_opt;
    logic [31:0] m_v1, m_v2, m_imm;
    logic [3:0]  m_rob;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Operand after looking at the current broadcasts: {tag, value}.
    function automatic logic [35:0] resolve(input logic [3:0] s, input logic [31:0] v);
        if (s != 4'd0 && cdb_alu_valid && s == cdb_alu_src) return {4'd0, cdb_alu_val};
        if (s != 4'd0 && cdb_ld_valid && s == cdb_ld_src) return {4'd0, cdb_ld_val};
        return {s, v};
    endfunction

    // Reference: advance the slot array by one clock edge using the current inputs.
    task automatic model_edge();
        int iss, fr, nfree;
        if (!rst) begin
            for (int i = 0; i < RS; i++) m[i].busy = 0;
            m_ena = 0; m_full = 0; m_opt = '0; m_v1 = '0; m_v2 = '0; m_imm = '0; m_rob = '0;
            return;
        end
        if (!rdy) return;
        m_ena = 0;
        if (rb) begin
            for (int i = 0; i < RS; i++) m[i].busy = 0;
            m_full = 0;
            return;
        end
        iss = -1;
        fr  = -1;
        for (int i = 0; i < RS; i++) begin
            if (iss < 0 && m[i].busy && m[i].s1 == 4'd0 && m[i].s2 == 4'd0) iss = i;
            if (fr < 0 && !m[i].busy) fr = i;
        end
        for (int i = 0; i < RS; i++) begin
            if (m[i].busy) begin
                {m[i].s1, m[i].v1} = resolve(m[i].s1, m[i].v1);
                {m[i].s2, m[i].v2} = resolve(m[i].s2, m[i].v2);
            end
        end
        if (iss >= 0) begin
            m_ena = 1;
            m_opt = m[iss].opt; m_v1 = m[iss].v1; m_v2 = m[iss].v2;
            m_imm = m[iss].imm; m_rob = m[iss].rob;
            m[iss].busy = 0;
        end
        if (rs_ena) begin
            chk("alloc_has_slot", 32'(fr >= 0), 32'd1);
            if (fr >= 0) begin
                m[fr].busy = 1;
                m[fr].opt  = rs_opt;
                m[fr].imm  = rs_imm;
                m[fr].rob  = rs_rob_idx;
                {m[fr].s1, m[fr].v1} = resolve(rs_src1, rs_val1);
                {m[fr].s2, m[fr].v2} = resolve(rs_src2, rs_val2);
            end
        end
        nfree = 0;
        for (int i = 0; i < RS; i++) if (!m[i].busy) nfree++;
        m_full = (nfree < 2);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("alu_ena", 32'(alu_ena), 32'(m_ena));
        chk("rs_full", 32'(rs_full), 32'(m_full));
        chk("alu_opt", 32'(alu_opt), 32'(m_opt));
        chk("alu_val1", alu_val1, m_v1);
        chk("alu_val2", alu_val2, m_v2);
        chk("alu_imm", alu_imm, m_imm);
        chk("alu_rob_idx", 32'(alu_rob_idx), 32'(m_rob));
    endtask

    task automatic set_alloc(input logic [5:0] opt, input logic [3:0] s1, input logic [31:0] v1,
                             input logic [3:0] s2, input logic [31:0] v2,
                             input logic [31:0] imm, input logic [3:0] rob);
        rs_ena = 1'b1; rs_opt = opt; rs_src1 = s1; rs_val1 = v1;
        rs_src2 = s2; rs_val2 = v2; rs_imm = imm; rs_rob_idx = rob;
    endtask

    task automatic idle_inputs();
        rs_ena = 1'b0; rs_opt = '0; rs_src1 = '0; rs_src2 = '0; rs_val1 = '0;
        rs_val2 = '0; rs_imm = '0; rs_rob_idx = '0; rb = 1'b0;
        cdb_alu_valid = 1'b0; cdb_alu_src = '0; cdb_alu_val = '0;
        cdb_ld_valid = 1'b0; cdb_ld_src = '0; cdb_ld_val = '0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        rdy = 1'b1;
        tick();
        tick();
        chk("reset_alu_ena", 32'(alu_ena), 32'd0);
        chk("reset_rs_full", 32'(rs_full), 32'd0);
        rst = 1'b1;

        // Ready op: issues one edge after it is written, for exactly one cycle.
        set_alloc(6'h01, 4'd0, 32'd5, 4'd0, 32'd7, 32'd0, 4'd3);
        tick();
        rs_ena = 1'b0;
        chk("add_early", 32'(alu_ena), 32'd0);
        tick();
        chk("add_ena", 32'(alu_ena), 32'd1);
        chk("add_val1", alu_val1, 32'd5);
        chk("add_val2", alu_val2, 32'd7);
        chk("add_rob", 32'(alu_rob_idx), 32'd3);
        tick();
        chk("add_ena_drop", 32'(alu_ena), 32'd0);

        // Wake-up from the ALU bus.
        set_alloc(6'h02, 4'd2, 32'd0, 4'd0, 32'd1, 32'd0, 4'd6);
        tick();
        rs_ena = 1'b0;
        tick();
        cdb_alu_valid = 1'b1; cdb_alu_src = 4'd2; cdb_alu_val = 32'h10;
        tick();
        idle_inputs();
        chk("dep_wait", 32'(alu_ena), 32'd0);
        tick();
        chk("dep_ena", 32'(alu_ena), 32'd1);
        chk("dep_val1", alu_val1, 32'h10);
        chk("dep_val2", alu_val2, 32'd1);

        // Same-cycle forwarding from the load bus into the new entry.
        set_alloc(6'h03, 4'd4, 32'd0, 4'd0, 32'd9, 32'd0, 4'd8);
        cdb_ld_valid = 1'b1; cdb_ld_src = 4'd4; cdb_ld_val = 32'hAB;
        tick();
        idle_inputs();
        tick();
        chk("fwd_ena", 32'(alu_ena), 32'd1);
        chk("fwd_val1", alu_val1, 32'hAB);

        // Fill until full, release, check slot-order issue and rs_full dropping.
        for (int i = 0; i < RS - 1; i++) begin
            set_alloc(6'(i), 4'd5, 32'd0, 4'd0, 32'(i), 32'(i), 4'(i));
            tick();
        end
        idle_inputs();
        chk("fill_full", 32'(rs_full), 32'd1);
        cdb_alu_valid = 1'b1; cdb_alu_src = 4'd5; cdb_alu_val = 32'h55;
        tick();
        idle_inputs();
        for (int i = 0; i < RS - 1; i++) begin
            tick();
            chk("order_ena", 32'(alu_ena), 32'd1);
            chk("order_rob", 32'(alu_rob_idx), 32'(i));
            if (i == 0) chk("full_drop", 32'(rs_full), 32'd0);
        end
        tick();

        // Rollback with a concurrent allocate: nothing survives.
        for (int i = 0; i < 4; i++) begin
            set_alloc(6'h04, 4'd7, 32'd0, 4'd0, 32'd0, 32'd0, 4'(i + 1));
            tick();
        end
        set_alloc(6'h05, 4'd0, 32'd1, 4'd0, 32'd2, 32'd0, 4'd12);
        rb = 1'b1;
        tick();
        idle_inputs();
        chk("rb_ena", 32'(alu_ena), 32'd0);
        chk("rb_full", 32'(rs_full), 32'd0);
        cdb_alu_valid = 1'b1; cdb_alu_src = 4'd7; cdb_alu_val = 32'h77;
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rb_no_issue", 32'(alu_ena), 32'd0);
        end

        // Stall with a ready entry waiting.
        set_alloc(6'h06, 4'd0, 32'd3, 4'd0, 32'd4, 32'd5, 4'd9);
        tick();
        idle_inputs();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_ena", 32'(alu_ena), 32'd0);
        end
        rdy = 1'b1;
        tick();
        chk("stall_issue", 32'(alu_ena), 32'd1);
        chk("stall_rob", 32'(alu_rob_idx), 32'd9);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(511) != 0);
            rdy = ($urandom_range(7) != 0);
            rb  = ($urandom_range(63) == 0);
            rs_ena     = !m_full && ($urandom_range(2) != 0);
            rs_opt     = 6'($urandom);
            rs_src1    = ($urandom_range(1) != 0) ? 4'd0 : 4'($urandom_range(7, 1));
            rs_src2    = ($urandom_range(1) != 0) ? 4'd0 : 4'($urandom_range(7, 1));
            rs_val1    = $urandom;
            rs_val2    = $urandom;
            rs_imm     = $urandom;
            rs_rob_idx = 4'($urandom);
            cdb_alu_valid = ($urandom_range(1) != 0);
            cdb_alu_src   = 4'($urandom_range(7));
            cdb_alu_val   = $urandom;
            cdb_ld_valid  = ($urandom_range(2) == 0);
            cdb_ld_src    = 4'($urandom_range(7));
            cdb_ld_val    = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
